// File: rtl/mcs4_pkg.sv
// rtl/mcs4_pkg.sv - shared MCS-4 bus types and instruction-cycle phases
package mcs4;

  typedef logic [3:0]  char_t;
  typedef logic [7:0]  byte_t;
  typedef logic [11:0] addr_t;

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } instr_cyc_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/mcs4_fetch_master.sv
// rtl/mcs4_fetch_master.sv - MCS-4 instruction fetch master driving the ROM nibble bus
module mcs4_fetch_master
  import mcs4::*;
#(
  parameter addr_t RESET_PC = 12'h000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       jump_req,
  input  addr_t      jump_addr,
  output logic       sync,
  output logic       cm_rom,
  output char_t      dbus_out,
  output logic       dbus_en,
  input  char_t      dbus_in,
  output logic       instr_valid,
  output byte_t      instr,
  output addr_t      instr_addr,
  output logic       busy
);

  fetch_state_t state, state_nxt;
  instr_cyc_t   phase, phase_nxt;
  addr_t        pc, pc_nxt;
  addr_t        jmp_addr_q;
  logic         jmp_pend;
  char_t        opr;
  logic         running;
  logic         pc_load;
  logic         has_jump;
  addr_t        jmp_target;

  assign running = (state == ST_RUN);

  // A request in the very cycle of the PC update wins over an older pending one.
  assign has_jump   = jump_req || jmp_pend;
  assign jmp_target = jump_req ? jump_addr : jmp_addr_q;
  assign pc_load    = (running && phase == X3) || (!running && run);
  assign pc_nxt     = has_jump ? jmp_target : (running ? pc + 12'd1 : pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= A1;
      pc         <= RESET_PC;
      jmp_pend   <= 1'b0;
      jmp_addr_q <= '0;
      opr        <= '0;
      instr      <= '0;
      instr_addr <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (pc_load) begin
        pc       <= pc_nxt;
        jmp_pend <= 1'b0;
      end else if (jump_req) begin
        jmp_pend   <= 1'b1;
        jmp_addr_q <= jump_addr;
      end
      if (running && phase == M1) opr <= dbus_in;
      if (running && phase == M2) begin
        instr      <= {opr, dbus_in};
        instr_addr <= pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      ST_IDLE: begin
        phase_nxt = A1;
        if (run) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (phase == X3) begin
          phase_nxt = A1;
          if (!run) state_nxt = ST_IDLE;
        end else begin
          phase_nxt = instr_cyc_t'(phase + 3'd1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dbus_out = 4'h0;
    dbus_en  = 1'b0;
    if (running) begin
      case (phase)
        A1:      begin dbus_out = pc[3:0];  dbus_en = 1'b1; end
        A2:      begin dbus_out = pc[7:4];  dbus_en = 1'b1; end
        A3, X2:  begin dbus_out = pc[11:8]; dbus_en = 1'b1; end
        default: begin dbus_out = 4'h0;     dbus_en = 1'b0; end
      endcase
    end
  end

  assign sync        = running && (phase == X3);
  assign cm_rom      = running && (phase == A3 || phase == X2);
  assign instr_valid = running && (phase == X1);
  assign busy        = running;

endmodule

// File: tb/tb_mcs4_fetch_master.sv
// tb/tb_mcs4_fetch_master.sv - directed self-checking bench for mcs4_fetch_master
module tb_mcs4_fetch_master;
  import mcs4::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        jump_req;
  addr_t       jump_addr;
  logic        sync, cm_rom, dbus_en, instr_valid, busy;
  char_t       dbus_out, dbus_in;
  byte_t       instr;
  addr_t       instr_addr;

  logic        b_sync, b_cm_rom, b_dbus_en, b_instr_valid, b_busy;
  char_t       b_dbus_out;
  char_t       b_dbus_in = 4'h0;
  byte_t       b_instr;
  addr_t       b_instr_addr;
  logic        b_jump_req = 1'b0;
  addr_t       b_jump_addr = 12'h000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcs4_fetch_master #(.RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .jump_req(jump_req), .jump_addr(jump_addr),
    .sync(sync), .cm_rom(cm_rom), .dbus_out(dbus_out), .dbus_en(dbus_en),
    .dbus_in(dbus_in), .instr_valid(instr_valid), .instr(instr),
    .instr_addr(instr_addr), .busy(busy)
  );

  mcs4_fetch_master #(.RESET_PC(12'hFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .jump_req(b_jump_req), .jump_addr(b_jump_addr),
    .sync(b_sync), .cm_rom(b_cm_rom), .dbus_out(b_dbus_out), .dbus_en(b_dbus_en),
    .dbus_in(b_dbus_in), .instr_valid(b_instr_valid), .instr(b_instr),
    .instr_addr(b_instr_addr), .busy(b_busy)
  );

  // ROM model: collects the three address nibbles, then returns OPR/OPA on M1/M2.
  logic [11:0] rom_a;
  int          rom_idx;
  int          rom_m;
  logic [7:0]  rom_d;
  assign rom_d   = rom_a[7:0] ^ 8'hA5;
  assign dbus_in = (rom_m == 1) ? rom_d[7:4] : (rom_m == 2) ? rom_d[3:0] : 4'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_idx <= 0;
      rom_m   <= 0;
      rom_a   <= 12'h000;
    end else if (sync) begin
      rom_idx <= 0;
    end else if (dbus_en && rom_idx < 3) begin
      rom_a[rom_idx*4 +: 4] <= dbus_out;
      rom_idx <= rom_idx + 1;
      if (rom_idx == 2) rom_m <= 1;
    end else if (rom_m == 1) begin
      rom_m <= 2;
    end else if (rom_m == 2) begin
      rom_m <= 0;
    end
  end

  function automatic logic [7:0] rom_of(input logic [11:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sync"}, sync, 0);
    check({tag, "_cm"}, cm_rom, 0);
    check({tag, "_en"}, dbus_en, 0);
    check({tag, "_dout"}, dbus_out, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Walks one instruction cycle fetched from a, optionally injecting a jump or run drop.
  task automatic fetch(input logic [11:0] a, input int jph, input logic [11:0] ja,
                       input int drop, input bit chk_b, input logic [11:0] b_a);
    int n;
    logic [3:0] en_nib;
    n = 0;
    do begin
      @(negedge clk);
      jump_req = 1'b0;
      n++;
    end while (!dbus_en && n < 40);
    if (!dbus_en) begin
      check("a1_timeout", 0, 1);
      return;
    end
    for (int ph = 0; ph < 8; ph++) begin
      if (ph > 0) @(negedge clk);
      if (ph == jph) begin
        jump_req  = 1'b1;
        jump_addr = ja;
      end else begin
        jump_req = 1'b0;
      end
      if (ph == drop) run = 1'b0;
      case (ph)
        0:       en_nib = a[3:0];
        1:       en_nib = a[7:4];
        2, 6:    en_nib = a[11:8];
        default: en_nib = 4'h0;
      endcase
      check($sformatf("en_%03h_p%0d", a, ph), dbus_en, (ph < 3 || ph == 6));
      check($sformatf("dout_%03h_p%0d", a, ph), dbus_out, en_nib);
      check($sformatf("sync_%03h_p%0d", a, ph), sync, (ph == 7));
      check($sformatf("cm_%03h_p%0d", a, ph), cm_rom, (ph == 2 || ph == 6));
      check($sformatf("valid_%03h_p%0d", a, ph), instr_valid, (ph == 5));
      check($sformatf("busy_%03h_p%0d", a, ph), busy, 1);
      if (ph == 5) begin
        check($sformatf("instr_%03h", a), instr, rom_of(a));
        check($sformatf("iaddr_%03h", a), instr_addr, a);
        if (chk_b) begin
          check($sformatf("b_valid_%03h", b_a), b_instr_valid, 1);
          check($sformatf("b_iaddr_%03h", b_a), b_instr_addr, b_a);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    jump_req  = 1'b0;
    jump_addr = 12'h000;
    #1;
    check_quiet("rst");
    check("rst_instr", instr, 0);
    check("rst_iaddr", instr_addr, 0);
    repeat (3) @(negedge clk);
    run   = 1'b1;
    rst_n = 1'b1;

    fetch(12'h000, -1, 12'h000, -1, 1'b1, 12'hFFF);
    fetch(12'h001, -1, 12'h000, -1, 1'b1, 12'h000);

    fetch(12'h002, 3, 12'h3C7, -1, 1'b0, 12'h000);
    fetch(12'h3C7, -1, 12'h000, -1, 1'b0, 12'h000);

    fetch(12'h3C8, 7, 12'h100, -1, 1'b0, 12'h000);
    fetch(12'h100, 1, 12'h200, -1, 1'b0, 12'h000);
    fetch(12'h200, -1, 12'h000, -1, 1'b0, 12'h000);

    fetch(12'h201, -1, 12'h000, 1, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      jump_req = 1'b0;
      check_quiet($sformatf("idle%0d", i));
      check("idle_hold_iaddr", instr_addr, 12'h201);
    end
    run = 1'b1;
    fetch(12'h202, -1, 12'h000, 7, 1'b0, 12'h000);

    @(negedge clk);
    jump_req  = 1'b0;
    check_quiet("idle_b");
    jump_req  = 1'b1;
    jump_addr = 12'h5A3;
    @(negedge clk);
    jump_req  = 1'b0;
    check_quiet("idle_jmp");
    run = 1'b1;
    fetch(12'h5A3, -1, 12'h000, -1, 1'b0, 12'h000);

    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!dbus_en && n < 40);
      check("rst_a1_seen", dbus_en, 1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_quiet("mrst");
      check("mrst_instr", instr, 0);
      check("mrst_iaddr", instr_addr, 0);
      @(negedge clk);
      check("mrst_novalid", instr_valid, 0);
      rst_n = 1'b1;
    end
    fetch(12'h000, -1, 12'h000, -1, 1'b0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/mcs4_fetch_master.md
MCS4_FETCH_MASTER -- requirements
Module: mcs4_fetch_master

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000: program counter value loaded at reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port run  input  1  1 = keep fetching; 0 = stop at the next instruction-cycle boundary.
REQ-005 SHALL have port jump_req  input  1  request to redirect the PC; single-cycle pulse.
REQ-006 SHALL have port jump_addr  input  12  target address, sampled with jump_req.
REQ-007 SHALL have port sync  output  1  instruction-cycle marker to ROMs; high during X3.
REQ-008 SHALL have port cm_rom  output  1  ROM command line; high during A3 and X2.
REQ-009 SHALL have port dbus_out  output  mcs4::char_t  nibble driven to the ROMs.
REQ-010 SHALL have port dbus_en  output  1  1 when dbus_out is valid.
REQ-011 SHALL have port dbus_in  input  mcs4::char_t  nibble returned by the ROMs.
REQ-012 SHALL have port instr_valid  output  1  one-cycle pulse when an instruction is complete.
REQ-013 SHALL have port instr  output  mcs4::byte_t  fetched instruction {OPR, OPA}.
REQ-014 SHALL have port instr_addr  output  12  PC the instruction was fetched from.
REQ-015 SHALL have port busy  output  1  1 while an instruction cycle is in progress.

Function
REQ-016 SHALL run an 8-phase instruction cycle of type mcs4::instr_cyc_t, in the order A1,A2,A3,M1,M2,X1,X2,X3, advancing one phase per clk.
REQ-017 SHALL have states IDLE and RUN; IDLE->RUN when run=1 (the first cycle is A1); RUN->IDLE after X3 when run=0 in the X3 cycle; otherwise X3->A1.
REQ-018 SHALL assert sync for exactly the X3 cycle of every instruction cycle, and keep it low in IDLE.
REQ-019 SHALL drive PC[3:0] in A1, PC[7:4] in A2, PC[11:8] in A3, and PC[11:8] (chip select) in X2, with dbus_en=1 in exactly those phases.
REQ-020 SHALL drive dbus_out=4'h0 whenever dbus_en=0.
REQ-021 SHALL sample dbus_in at the clk edge ending M1 into OPR (instr[7:4]) and at the edge ending M2 into OPA (instr[3:0]).
REQ-022 SHALL pulse instr_valid for the X1 cycle, with instr and instr_addr stable and held until the next pulse.
REQ-023 SHALL update the PC at the X3->A1 (or X3->IDLE) edge: to jump_addr if a jump is pending, else PC+1 modulo 4096 (12'hFFF wraps to 12'h000).
REQ-024 SHALL latch jump_req/jump_addr in any phase or state into a one-deep pending register; a later request before the update overwrites it (last wins).
REQ-025 SHALL apply a jump received in the X3 cycle itself at that cycle's PC update.
REQ-026 SHALL apply a pending jump in IDLE at the next IDLE->RUN, so the first A1 drives jump_addr.
REQ-027 SHALL finish the current instruction cycle when run falls mid-cycle, including its instr_valid.
REQ-028 SHALL hold busy=1 from A1 through X3 and busy=0 in IDLE.

Reset
REQ-029 SHALL on rst_n=0 immediately (asynchronously) force: state IDLE, phase A1, PC=RESET_PC, pending jump cleared, sync=0, cm_rom=0, dbus_en=0, dbus_out=0, instr_valid=0, instr=0, instr_addr=0, busy=0.
REQ-030 SHALL abandon any partial instruction cycle on reset, with no instr_valid; after release the first fetch is from RESET_PC.

Structure
REQ-031 SHALL take char_t, byte_t, instr_cyc_t (A1=0..X3=7) and a new addr_t (12-bit) from package mcs4; jump_addr, instr_addr and the PC SHALL use mcs4::addr_t.
REQ-032 SHALL be a single module, with the phase counter and state register inline; no sub-module.

Verification
REQ-033 Reset release, run=1, ROM model holding 8'hA5 at 12'h000 -> nibbles 0,0,0 on A1-A3, 0 on X2, sync in X3, instr_valid with instr=8'hA5, instr_addr=12'h000; the next cycle fetches 12'h001.
REQ-034 RESET_PC=12'hFFF, run=1 -> first instr_addr=12'hFFF, second 12'h000 (wrap).
REQ-035 jump_req with 12'h3C7 during M1 -> the next cycle drives 7,C,3 on A1-A3 and 3 on X2; instr_addr=12'h3C7.
REQ-036 jump_req 12'h100 in X3 and again 12'h200 during the next A2 -> the next fetch is from 12'h100, the one after from 12'h200.
REQ-037 run dropped during A2 -> cycle completes with instr_valid, then IDLE (sync, busy, dbus_en low); run=1 resumes at PC+1.
REQ-038 rst_n low during M2 -> all outputs zero in the same cycle, no instr_valid; after release the fetch restarts at RESET_PC.
